// File: rtl/flash_boot_copier.sv
// Boot copier: streams an image from the SPI flash reader into on-chip RAM, holding the CPU in reset until done.
// Optional BOOT_CHECKSUM_EN adds a trailing checksum word read and gates the CPU release on it.
module flash_boot_copier #(
    parameter logic [19:0] FLASH_BASE  = 20'h10000,
    parameter int          RAM_BASE    = 0,
    parameter int          NWORDS      = 1024,
    parameter int          RAM_AW      = 16,
    parameter int          ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              flash_rstrb,
    output logic [19:0]       flash_word_address,
    input  logic [31:0]       flash_rdata,
    input  logic              flash_rbusy,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              checksum_ok
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, REQ, WAIT_ACK, WAIT_DATA, WRITE,
        CHK_REQ, CHK_ACK, CHK_WAIT, DONE, ERROR
    } state_t;

    state_t        state, state_n;
    logic [15:0]   count, cnt_n;
    logic [TW-1:0] timer;
    logic [31:0]   ram_sum;
    logic          last, starting, ack_expired;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]   acc;
`endif

    assign last        = (count == 16'(NWORDS - 1));
    assign starting    = start && (state == IDLE || state == DONE);
    // timer counts cycles elapsed since the strobe cycle
    assign ack_expired = (32'(timer) >= ACK_TIMEOUT - 1);
    assign ram_sum     = 32'(RAM_BASE) + 32'(count);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:      if (start) state_n = REQ;
            REQ:       state_n = WAIT_ACK;
            WAIT_ACK:  if (flash_rbusy) state_n = WAIT_DATA;
                       else if (ack_expired) state_n = ERROR;
            WAIT_DATA: if (!flash_rbusy) state_n = WRITE;
`ifdef BOOT_CHECKSUM_EN
            WRITE:     state_n = last ? CHK_REQ : REQ;
`else
            WRITE:     state_n = last ? DONE : REQ;
`endif
            CHK_REQ:   state_n = CHK_ACK;
            CHK_ACK:   if (flash_rbusy) state_n = CHK_WAIT;
                       else if (ack_expired) state_n = ERROR;
            CHK_WAIT:  if (!flash_rbusy) state_n = DONE;
            DONE:      if (start) state_n = REQ;
            ERROR:     state_n = ERROR;
            default:   state_n = IDLE;
        endcase
    end

    always_comb begin
        cnt_n = count;
        if (starting) cnt_n = 16'd0;
        else if (state == WRITE && !last) cnt_n = count + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flash_word_address <= '0;
            ram_addr           <= '0;
            ram_wdata          <= '0;
            checksum_ok        <= 1'b0;
            count              <= '0;
            timer              <= '0;
`ifdef BOOT_CHECKSUM_EN
            acc                <= '0;
`endif
        end else begin
            count <= cnt_n;
            if (state_n == REQ)
                flash_word_address <= FLASH_BASE + 20'(cnt_n);
            if (state_n == CHK_REQ)
                flash_word_address <= FLASH_BASE + 20'(NWORDS);
            if (state_n == WRITE)
                ram_addr <= ram_sum[RAM_AW-1:0];
            if (state == WAIT_DATA && !flash_rbusy)
                ram_wdata <= flash_rdata;
            if (state == REQ || state == CHK_REQ)
                timer <= TW'(1);
            else if (state == WAIT_ACK || state == CHK_ACK)
                timer <= timer + 1'b1;
`ifdef BOOT_CHECKSUM_EN
            if (starting) begin
                acc         <= '0;
                checksum_ok <= 1'b0;
            end else if (state == WRITE) begin
                acc <= acc + ram_wdata;
            end else if (state == CHK_WAIT && !flash_rbusy) begin
                checksum_ok <= (flash_rdata == acc);
            end
`else
            if (starting)
                checksum_ok <= 1'b0;
            else if (state == WRITE && last)
                checksum_ok <= 1'b1;
`endif
        end
    end

    always_comb begin
        flash_rstrb = 1'b0;
        ram_we      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        cpu_hold    = 1'b1;
        unique case (state)
            REQ, CHK_REQ: begin
                flash_rstrb = 1'b1;
                busy        = 1'b1;
            end
            WAIT_ACK, WAIT_DATA, CHK_ACK, CHK_WAIT: busy = 1'b1;
            WRITE: begin
                ram_we = 1'b1;
                busy   = 1'b1;
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = !checksum_ok;
            end
            ERROR:   error = 1'b1;
            default: ;
        endcase
    end
endmodule
